// File: rtl/instr_encoder_pkg.sv
// RV32I opcode constants, encoding-format enum and opcode-to-format decode
// shared by the instruction encoder files.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  function automatic fmt_e opc_to_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LOAD, OPC_ITYPE, OPC_JALR: f = FMT_I;
      OPC_STORE:                     f = FMT_S;
      OPC_BRANCH:                    f = FMT_B;
      OPC_LUI, OPC_AUIPC:            f = FMT_U;
      OPC_JAL:                       f = FMT_J;
      OPC_OP:                        f = FMT_R;
      default:                       f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational field packer: builds the 32-bit word for a given format and
// flags out-of-range immediates when INSTR_ENC_RANGECHK_EN is defined.
module imm_packer
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  input  fmt_e        fmt_i,
  output logic [31:0] instr_o,
  output logic        range_err_o
);

  always_comb begin
    instr_o = NOP_INSTR;
    case (fmt_i)
      FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: instr_o = NOP_INSTR;
    endcase
  end

`ifdef INSTR_ENC_RANGECHK_EN
  // Sign-extension check: the bits above the field width must all match.
  logic ext_i_ok, ext_b_ok, ext_j_ok;
  assign ext_i_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign ext_b_ok = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign ext_j_ok = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: range_err_o = !ext_i_ok;
      FMT_B:        range_err_o = imm_i[0] | !ext_b_ok;
      FMT_J:        range_err_o = imm_i[0] | !ext_j_ok;
      FMT_U:        range_err_o = |imm_i[11:0];
      default:      range_err_o = 1'b0;
    endcase
  end
`else
  logic unused_imm0;
  assign unused_imm0 = imm_i[0];
  assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: format decode, main+skid output buffer, counters.
// Optional immediate range checking is enabled with INSTR_ENC_RANGECHK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  // Handshake: a beat transfers on a side in any cycle where valid & ready
  // are both high at the rising edge; valid never depends on ready.

  fmt_e        fmt;
  logic [31:0] enc_instr;
  logic        enc_range_err;
  logic        enc_err;

  assign fmt = opc_to_fmt(in_opcode);

  imm_packer u_packer (
    .opcode_i    (in_opcode),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .funct3_i    (in_funct3),
    .funct7_i    (in_funct7),
    .imm_i       (in_imm),
    .fmt_i       (fmt),
    .instr_o     (enc_instr),
    .range_err_o (enc_range_err)
  );

  assign enc_err = (fmt == FMT_BAD) | enc_range_err;

  logic        main_valid_q, main_valid_d;
  logic [31:0] main_instr_q, main_instr_d;
  logic        main_err_q,   main_err_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_err_q,   skid_err_d;
  logic [15:0] enc_count_q,  enc_count_d;
  logic [7:0]  err_count_q,  err_count_d;

  logic accept;
  logic out_fire;

  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign out_fire  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_err_d   = skid_err_q;

    if (out_fire) begin
      if (skid_valid_q) begin
        // Skid full implies no accept this cycle; promote it to main.
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_instr_d = enc_instr;
        main_err_d   = enc_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = enc_instr;
        main_err_d   = enc_err;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = enc_instr;
        skid_err_d   = enc_err;
      end
    end

    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (out_fire) begin
      enc_count_d = enc_count_q + 16'd1;
      if (main_err_q && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= 32'h0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_err_q   <= 1'b0;
      enc_count_q  <= 16'h0;
      err_count_q  <= 8'h0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_err_q   <= skid_err_d;
      enc_count_q  <= enc_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_instr = main_instr_q;
  assign out_err   = main_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; expectations are hand-encoded RV32I words.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int tests_run;
  int tests_failed;
  int exp_enc;
  int exp_errc;
  logic [31:0] exp_q[$];

`ifdef INSTR_ENC_RANGECHK_EN
  localparam logic RANGECHK = 1'b1;
`else
  localparam logic RANGECHK = 1'b0;
`endif

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_enc = 0;
    exp_errc = 0;
    exp_q.delete();
  endtask

  // Driver: set request fields (call at a negedge)
  task automatic drive(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  // One beat through an idle encoder with out_ready high; checks word, error and counters.
  task automatic send_check(input string name, input logic [6:0] opc, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_instr, input logic exp_err);
    @(negedge clk);
    out_ready = 1'b1;
    drive(opc, rd, rs1, rs2, f3, f7, imm);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_instr !== exp_instr) begin
      tests_failed++;
      $display("FAIL %s instr: got valid=%b 0x%08h, expected valid=1 0x%08h",
               name, out_valid, out_instr, exp_instr);
    end
    tests_run++;
    if (out_err !== exp_err) begin
      tests_failed++;
      $display("FAIL %s err: got %b, expected %b", name, out_err, exp_err);
    end
    exp_enc++;
    if (exp_err && exp_errc < 255) exp_errc++;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || enc_count !== exp_enc[15:0] || err_count !== exp_errc[7:0]) begin
      tests_failed++;
      $display("FAIL %s counters: got valid=%b enc=%0d err=%0d, expected valid=0 enc=%0d err=%0d",
               name, out_valid, enc_count, err_count, exp_enc, exp_errc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_err !== 1'b0 ||
        enc_count !== 16'h0 || err_count !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b ready=%b instr=0x%08h err=%b enc=%0d errc=%0d, expected 0 1 0 0 0 0",
               out_valid, in_ready, out_instr, out_err, enc_count, err_count);
    end
    exp_enc = 0;
    exp_errc = 0;
  endtask

  task automatic test_formats();
    send_check("itype_addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd5,        32'h0050_0093, 1'b0);
    send_check("store_sw",   7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'h0, 32'hFFFF_FFFC, 32'hFE21_AE23, 1'b0);
    send_check("lui",        7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send_check("jal",        7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send_check("rtype_sub",  7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
    send_check("bne_neg",    7'b1100011, 5'd0, 5'd1, 5'd2, 3'b001, 7'h0, 32'hFFFF_FFF8, 32'hFE20_9CE3, 1'b0);
    send_check("jalr_m1",    7'b1100111, 5'd1, 5'd5, 5'd0, 3'b000, 7'h0, 32'hFFFF_FFFF, 32'hFFF2_80E7, 1'b0);
  endtask

  task automatic test_illegal();
    send_check("illegal_opc", 7'h7F, 5'd1, 5'd2, 5'd3, 3'b111, 7'h7F, 32'h1234_5678, 32'h0000_0013, 1'b1);
  endtask

  task automatic test_range();
    // Bit 0 is dropped from the word in both builds; only the flag differs.
    send_check("branch_odd", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h0, 32'd3, 32'h0020_8163, RANGECHK);
    send_check("itype_wide", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'h0000_0800, 32'h8000_0093, RANGECHK);
    send_check("lui_lowbits", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h0, 32'h1234_5001, 32'h1234_52B7, RANGECHK);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    apply_reset();
    @(negedge clk);
    out_ready = 1'b0;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd1);
    exp_q.push_back(32'h0010_0093);
    @(negedge clk);
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd2);
    exp_q.push_back(32'h0020_0093);
    @(negedge clk);
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd3);
    exp_q.push_back(32'h0030_0093);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL b2b_stall: got ready=%b valid=%b instr=0x%08h, expected ready=0 valid=1 instr=0x%08h",
               in_ready, out_valid, out_instr, exp_q[0]);
    end
    @(negedge clk);
    tests_run++;
    if (out_instr !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL b2b_hold: got 0x%08h, expected 0x%08h", out_instr, exp_q[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        tests_run++;
        if (in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_ready_rise: got %b, expected 1", in_ready);
        end
      end
      if (i == 1) in_valid = 1'b0;
      void'(exp_q.pop_front());
      exp_w = exp_q.size() > 0 ? exp_q[0] : 32'h0;
      if (i < 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_instr !== exp_w) begin
          tests_failed++;
          $display("FAIL b2b_order_%0d: got valid=%b 0x%08h, expected valid=1 0x%08h",
                   i + 1, out_valid, out_instr, exp_w);
        end
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || enc_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL b2b_count: got valid=%b enc=%0d, expected valid=0 enc=3", out_valid, enc_count);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'h0, 32'd7);
    @(negedge clk);
    drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'b000, 7'h0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_full: got ready=%b valid=%b, expected ready=0 valid=1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'h0 || err_count !== 8'h0) begin
      tests_failed++;
      $display("FAIL midreset_async: got valid=%b ready=%b enc=%0d err=%0d, expected 0 1 0 0",
               out_valid, in_ready, enc_count, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || enc_count !== 16'h0) begin
        tests_failed++;
        $display("FAIL midreset_stale_%0d: got valid=%b enc=%0d, expected valid=0 enc=0",
                 i, out_valid, enc_count);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_formats();
    test_illegal();
    test_range();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
